// File: rtl/fp_accum_seq_if.sv
// Stream, adder and result signals of the bf16 accumulation sequencer.
// The DUT side uses the slave modport; the driver/adder side uses master.
interface fp_accum_seq_if #(
   parameter int COUNT_W = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [15:0]        in_data;
   logic               in_last;
   logic [15:0]        add_a;
   logic [15:0]        add_b;
   logic [15:0]        add_sum;
   logic               out_valid;
   logic               out_ready;
   logic [15:0]        out_data;
   logic [COUNT_W-1:0] out_count;

   modport slave (
      input  in_valid, in_data, in_last, add_sum, out_ready,
      output in_ready, add_a, add_b, out_valid, out_data, out_count
   );

   modport master (
      output in_valid, in_data, in_last, add_sum, out_ready,
      input  in_ready, add_a, add_b, out_valid, out_data, out_count
   );
endinterface

// File: rtl/fp_accum_seq.sv
// Streaming bf16 accumulation sequencer feeding an external combinational adder.
// The first element of a packet is loaded, not added, since the adder has no zero encoding.
module fp_accum_seq #(
   parameter int COUNT_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   fp_accum_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      LOAD,
      ACCUM,
      ADD,
      OUT
   } state_t;

   localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
   localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

   state_t             state;
   state_t             next_state;
   logic [15:0]        acc;
   logic [15:0]        add_a_q;
   logic [15:0]        add_b_q;
   logic [COUNT_W-1:0] count;
   logic               last_q;
   logic               in_ready_c;
   logic               out_valid_c;
   logic               accept;

   assign accept = bus.in_valid && in_ready_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LOAD;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         LOAD:    if (accept) next_state = bus.in_last ? OUT : ACCUM;
         ACCUM:   if (accept) next_state = ADD;
         ADD:     next_state = last_q ? OUT : ACCUM;
         OUT:     if (bus.out_ready) next_state = LOAD;
         default: next_state = LOAD;
      endcase
   end

   // Input is blocked while reset is high so nothing is lost in the reset cycle.
   always_comb begin
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         LOAD, ACCUM: in_ready_c  = !reset;
         OUT:         out_valid_c = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc     <= '0;
         add_a_q <= '0;
         add_b_q <= '0;
         count   <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (accept) begin
                  acc   <= bus.in_data;
                  count <= COUNT_ONE;
               end
            end
            ACCUM: begin
               if (accept) begin
                  add_a_q <= acc;
                  add_b_q <= bus.in_data;
                  last_q  <= bus.in_last;
               end
            end
            ADD: begin
               acc <= bus.add_sum;
               if (count != COUNT_MAX) begin
                  count <= count + COUNT_ONE;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.out_data  = acc;
   assign bus.out_count = count;

endmodule

// File: doc/fp_accum_seq.md
# fp_accum_seq

Streaming bfloat16 accumulation sequencer that sits directly upstream of the team's combinational bfloat16 adder. It accepts a packet of bf16 values over a valid/ready stream, presents operand pairs to the adder on registered outputs, captures the adder's sum, and returns one accumulated result per packet with an element count. The first element of a packet is loaded directly into the accumulator, not added, because the adder's implicit-leading-one format has no zero encoding.

## Interface
- COUNT_W, default 8: width of the element counter and `out_count`.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_ready  out  1  sequencer can accept an element this cycle.
- in_data  in  16  bf16 element: {sign, exp[7:0], mant[6:0]}.
- in_last  in  1  element is the final one of its packet.
- add_a  out  16  registered operand A to adder (running sum).
- add_b  out  16  registered operand B to adder (new element).
- add_sum  in  16  combinational adder result for add_a + add_b.
- out_valid  out  1  accumulated result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  16  accumulated bf16 sum of the packet.
- out_count  out  COUNT_W  number of elements in the packet, saturating.

## Operation
- States: LOAD (expect first element), ACCUM (expect next element), ADD (capture adder output), OUT (hold result).
- Accept = in_valid && in_ready. in_ready = 1 in LOAD and ACCUM only; 0 in ADD, OUT, and in any cycle with reset high.
- LOAD, accept: acc <= in_data; count <= 1; next = OUT if in_last, else ACCUM.
- ACCUM, accept: add_a <= acc; add_b <= in_data; last_q <= in_last; next = ADD.
- ADD: acc <= add_sum; count <= count+1, saturating at 2^COUNT_W-1; next = OUT if last_q, else ACCUM. No input accepted.
- OUT: out_valid = 1; out_data = acc; out_count = count. On out_valid && out_ready: next = LOAD. out_data and out_count stay stable while out_valid is high and out_ready is low.
- No accept in LOAD or ACCUM: state and registers hold.
- add_a and add_b change only on an ACCUM accept and hold otherwise. The adder is combinational, so add_sum is valid in the cycle after the accept.
- Sign bits pass through untouched. Accumulation correctness for mixed signs is the adder's responsibility, not this block's.
- Arithmetic: the count increment is COUNT_W wide. No other arithmetic is done in this block.

## Timing
- Reset (synchronous): state = LOAD; acc, add_a, add_b, count, last_q = 0; out_valid = 0; out_data = 0; out_count = 0.
- in_ready rises the first cycle after reset deasserts.
- Throughput: first element takes 1 cycle; each further element takes 2 cycles (ACCUM accept, then ADD).
- Latency:
  - Last element accepted in ACCUM at cycle t: ADD at t+1, out_valid at t+2.
  - Single-element packet accepted at t: out_valid at t+1.
- Back-to-back packets: after the result handshake at cycle t, LOAD at t+1 and in_ready = 1 at t+1. No element is accepted in the handshake cycle itself.
- Reset mid-packet or mid-OUT: the partial sum and pending result are discarded, and all reset values apply next cycle.
- in_last on an element accepted in LOAD ends the packet immediately, with count = 1.
- Count saturation: the count stays at max. Accumulation continues normally.

## Test plan
- Reset with in_valid held high:
  - During reset: in_ready = 0, out_valid = 0, add_a = add_b = 0.
  - First cycle after reset: in_ready = 1.
- Packet {0x3F80, 0x3F80, 0x3F80(last)}, adder model attached, out_ready = 1:
  - Accepts occur at cycles 0, 1, 3.
  - Cycle 2: add_a = 0x3F80, add_b = 0x3F80, acc captures 0x4000.
  - out_valid at cycle 5 with out_data = 0x4040, out_count = 3.
- Single element 0x4000 with in_last:
  - out_valid the next cycle; out_data = 0x4000, out_count = 1.
  - add_a and add_b are untouched.
- Backpressure: packet {0x4000, 0x3F80(last)} with out_ready held low for 4 cycles:
  - out_data = 0x4040 and out_count = 2 hold stable; in_ready = 0 throughout.
  - Release: handshake, then LOAD the next cycle.
- Reset asserted in the ADD cycle of a 3-element packet:
  - All outputs return to reset values.
  - The next packet {0x3F80(last)} yields out_data = 0x3F80, out_count = 1.
- COUNT_W = 2, packet of 5 elements of 0x3F80:
  - out_count saturates at 3.
  - out_data matches the adder model's sequential sum.
